// File: rtl/rob_pkg.sv
// Purpose: shared defaults and width helpers for reorder-buffer blocks.
// Contents: default index width / port count, depth and counter-width helpers.
// Users: import rob_pkg::*; in any ROB block needing consistent sizing.
package rob_pkg;

  localparam int unsigned ROB_ADDR_WIDTH = 4;
  localparam int unsigned ROB_SET_PORTS  = 2;

  // Number of entries addressed by an index of the given width.
  function automatic int unsigned rob_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Bits needed to index 0..depth-1.
  function automatic int unsigned rob_idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Bits needed to hold an occupancy count 0..depth inclusive.
  function automatic int unsigned rob_cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rob_set_decode.sv
// Purpose: fold SET_PORTS indexed set strobes into one DEPTH-bit OR mask.
// Latency: purely combinational, zero cycles.
// Backpressure: none; every strobe is always absorbed into the mask.
// Ports: set_i/set_addr_i (per-port strobe and packed index, port p at
//        [p*ADDR_WIDTH +: ADDR_WIDTH]); mask_o (entries set this cycle);
//        multi_hit_o (two or more ports hit the same entry).
module rob_set_decode
  import rob_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ROB_ADDR_WIDTH,
  parameter int unsigned SET_PORTS  = ROB_SET_PORTS,
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH
) (
  input  logic [SET_PORTS-1:0]            set_i,
  input  logic [SET_PORTS*ADDR_WIDTH-1:0] set_addr_i,
  output logic [DEPTH-1:0]                mask_o,
  output logic                            multi_hit_o
);

  logic [DEPTH-1:0]      mask_d;
  logic                  multi_d;
  logic [ADDR_WIDTH-1:0] addr;

  // A port landing on a bit already claimed by a lower port is a multi-hit;
  // the entry still appears once in the mask so it is counted once.
  always_comb begin
    mask_d  = '0;
    multi_d = 1'b0;
    addr    = '0;
    for (int p = 0; p < SET_PORTS; p++) begin
      addr = set_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      if (set_i[p]) begin
        if (mask_d[addr]) begin
          multi_d = 1'b1;
        end
        mask_d[addr] = 1'b1;
      end
    end
  end

  assign mask_o      = mask_d;
  assign multi_hit_o = multi_d;

endmodule

// File: rtl/rob_valid_tracker.sv
// Purpose: multi-port ROB valid bitmap with in-order retire, occupancy count.
// Latency: sets/pops visible next cycle; rd_data_o returns one cycle after query.
// Backpressure: pop is honoured only while head_valid_o is high, else flagged.
// Ports: clk/rst (sync, active-high); set_i/set_addr_i completion ports;
//        pop_i retire head; flush_i clear table; rd_addr_i/rd_data_o query;
//        head_addr_o/head_valid_o head state; valid_cnt_o occupancy;
//        dup_err_o/pop_err_o sticky error flags (cleared only by rst).
module rob_valid_tracker
  import rob_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ROB_ADDR_WIDTH,
  parameter int unsigned SET_PORTS  = ROB_SET_PORTS,
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SET_PORTS-1:0]            set_i,
  input  logic [SET_PORTS*ADDR_WIDTH-1:0] set_addr_i,
  input  logic                            pop_i,
  input  logic                            flush_i,
  input  logic [ADDR_WIDTH-1:0]           rd_addr_i,
  output logic                            rd_data_o,
  output logic [ADDR_WIDTH-1:0]           head_addr_o,
  output logic                            head_valid_o,
  output logic [ADDR_WIDTH:0]             valid_cnt_o,
  output logic                            dup_err_o,
  output logic                            pop_err_o
);

  localparam int unsigned CNT_W = rob_cnt_width(DEPTH);

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rd_q, rd_d;
  logic                  dup_err_q, dup_err_d;
  logic                  pop_err_q, pop_err_d;

  logic [DEPTH-1:0]      set_mask;
  logic                  multi_hit;
  logic                  head_valid;
  logic                  pop_acc;
  logic [DEPTH-1:0]      clr_mask;
  logic [DEPTH-1:0]      new_bits;
  logic [CNT_W-1:0]      n_new;
  logic                  dec;

  rob_set_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SET_PORTS  (SET_PORTS)
  ) u_set_decode (
    .set_i       (set_i),
    .set_addr_i  (set_addr_i),
    .mask_o      (set_mask),
    .multi_hit_o (multi_hit)
  );

  // Head status comes only from registers, so pop acceptance never depends
  // combinationally on this cycle's sets.
  assign head_valid = valid_q[head_q];
  assign pop_acc    = pop_i & head_valid;

  always_comb begin
    clr_mask = '0;
    if (pop_acc) begin
      clr_mask[head_q] = 1'b1;
    end
  end

  // Entries going 0->1 this cycle. The popped entry was 1 beforehand, so a
  // same-cycle re-set of it is not new; instead it cancels the decrement.
  assign new_bits = set_mask & ~valid_q;
  assign dec      = pop_acc & ~set_mask[head_q];

  always_comb begin
    n_new = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (new_bits[i]) begin
        n_new = n_new + CNT_W'(1);
      end
    end
  end

  always_comb begin
    valid_d   = valid_q;
    head_d    = head_q;
    cnt_d     = cnt_q;
    rd_d      = valid_q[rd_addr_i];
    dup_err_d = dup_err_q;
    pop_err_d = pop_err_q;
    if (flush_i) begin
      // Flush discards same-cycle sets/pops, so they raise no errors either.
      valid_d = '0;
      head_d  = '0;
      cnt_d   = '0;
      rd_d    = 1'b0;
    end else begin
      valid_d = (valid_q & ~clr_mask) | set_mask;
      cnt_d   = cnt_q + n_new - CNT_W'(dec);
      if (pop_acc) begin
        head_d = head_q + ADDR_WIDTH'(1);
      end
      if (multi_hit || |(set_mask & valid_q & ~clr_mask)) begin
        dup_err_d = 1'b1;
      end
      if (pop_i && !head_valid) begin
        pop_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      head_q    <= '0;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      dup_err_q <= 1'b0;
      pop_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      head_q    <= head_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      dup_err_q <= dup_err_d;
      pop_err_q <= pop_err_d;
    end
  end

  assign rd_data_o    = rd_q;
  assign head_addr_o  = head_q;
  assign head_valid_o = head_valid;
  assign valid_cnt_o  = cnt_q;
  assign dup_err_o    = dup_err_q;
  assign pop_err_o    = pop_err_q;

endmodule

// File: doc/rob_valid_tracker.md
# rob_valid_tracker

Multi-port valid bitmap for the reorder buffer with in-order retirement and occupancy tracking. Generalises the single-port valid memory: several producers mark entries complete in one cycle, and a head pointer with a pop handshake retires entries in order, clearing each bit on retirement. A flush clears the whole table. Sits between the completion writeback ports and the ROB retire logic.

## Interface
- ADDR_WIDTH, 4, entry index width; depth DEPTH = 2**ADDR_WIDTH.
- SET_PORTS, 2, number of independent set (completion) ports, ≥1.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- set_i  in  SET_PORTS  per-port set strobe.
- set_addr_i  in  SET_PORTS×ADDR_WIDTH  per-port entry index.
- pop_i  in  1  retire request for the head entry.
- flush_i  in  1  clear all entries and return head to 0.
- rd_addr_i  in  ADDR_WIDTH  random-access query index.
- rd_data_o  out  1  registered valid bit of rd_addr_i.
- head_addr_o  out  ADDR_WIDTH  current head index.
- head_valid_o  out  1  valid bit at head; pop is accepted only when high.
- valid_cnt_o  out  ADDR_WIDTH+1  number of valid entries, 0..DEPTH.
- dup_err_o  out  1  sticky: set to an already-valid entry.
- pop_err_o  out  1  sticky: pop_i while head_valid_o low.

## Operation
- State: valid[DEPTH], head pointer, count register, rd_data register, two sticky error flags.
- Reset (rst=1): valid all 0, head 0, count 0, rd_data_o 0, both error flags 0. Reset overrides every other input.
- Flush (flush_i=1, rst=0): valid all 0, head 0, count 0, rd_data_o 0. Sets and pops in the same cycle are discarded. Error flags are held (only rst clears them).
- Set: each set_i[p] marks valid[set_addr_i[p]] = 1.
- Pop accepted = pop_i & head_valid_o: clears valid[head] and head increments modulo DEPTH (DEPTH-1 wraps to 0).
- Pop with head_valid_o=0: no state change, pop_err_o set.
- Set on the entry being popped in the same cycle: the bit ends at 1 (freed and refilled), no error, count unchanged.
- Set to an entry already valid and not being popped: bit stays 1, count unchanged, dup_err_o set.
- Two or more ports setting the same entry in one cycle: counted once; dup_err_o set.
- Count update: count_next = count + (number of distinct entries going 0→1) − (accepted pop and entry not re-set). The counter never exceeds DEPTH or goes below 0.
- Read port: rd_data_o <= valid[rd_addr_i], sampled from pre-update state (no bypass of same-cycle sets).

## Timing
- Set in cycle N: the bit is visible in cycle N+1 on head_valid_o and valid_cnt_o, and on rd_data_o when queried in cycle N+1 (data returned in N+2).
- head_valid_o and head_addr_o are driven from registers through the DEPTH:1 mux only. There is no combinational path from any input.
- Pop accepted in cycle N: head_addr_o advances in N+1, and head_valid_o in N+1 reflects the new head entry. Back-to-back pops every cycle are supported.
- Error flags assert in the cycle after the offending event and stay high until rst.
- Read latency 1 cycle, one query per cycle.

## Structure
- Package rob_pkg: default ADDR_WIDTH, and the function clog2-based width helpers used by ROB blocks.
- Sub-module rob_set_decode: converts SET_PORTS indexed sets into a DEPTH-bit one-hot OR mask plus a multi-hit flag. This mask drives both the bitmap update and the distinct-set popcount.
- Top holds the bitmap, head pointer, counter and error flags.

## Test plan
- Reset then idle: all outputs 0, head_addr_o=0, valid_cnt_o=0.
- Set entries 0,1 on ports 0/1 in one cycle, then pop twice back-to-back -> head_valid_o=1 in cycle 1; head_addr_o goes 0→1→2; valid_cnt_o goes 2→1→0; no errors.
- Fill all 16 entries (ADDR_WIDTH=4), then pop 16 times -> valid_cnt_o=16 peak; head wraps from 15 to 0; final count 0.
- Pop with head invalid -> pop_err_o=1 next cycle, head unchanged. Set the same entry 3 on both ports -> count +1, dup_err_o=1.
- Set on the head entry during its accepted pop -> bit remains 1, count unchanged, no dup_err_o. Flush with concurrent set of 5 -> all valid 0, head 0, count 0.
- rst asserted mid-fill (count=7) -> all outputs 0 the next cycle, including sticky error flags.
